count_monitor: RTL and testbench

Downstream consumer of the 4-bit counter's COUNT bus. It samples the count every enabled cycle and checks that each step is legal (+1, hold, wrap 15→0, or restart to 0). It raises one-cycle MATCH and WRAP event pulses, keeps a saturating wrap tally, and latches a sticky error on any illegal jump. It sits between the counter and the control/debug logic that needs period events without decoding COUNT itself.

---
 rtl/count_monitor.sv | 161 ++++++++++++++++
 tb/tb_count_monitor.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/count_monitor.sv
// count_monitor
// Watches the COUNT bus of a WIDTH-bit free-running counter.
// Each enabled cycle it checks that the count moved by a legal step:
//   +1, hold, wrap from max to 0, or restart to 0.
// It raises one-cycle MATCH and WRAP event pulses.
// It keeps a saturating tally of wraps.
// It latches a sticky STEP_ERR on any other jump.
//
// Ports
//   clk         rising-edge clock
//   reset       synchronous active-high reset, dominates everything
//   en          sampling enable; count_in is evaluated only when high
//   count_in    count value from the counter
//   match_load  loads match_val into the match register
//   match_val   match value to load
//   clr_err     clears step_err (a coincident illegal step wins)
//   match       one-cycle pulse when the count changes to the match value
//   wrap        one-cycle pulse on a max -> 0 step
//   wraps       saturating wrap tally
//   step_err    sticky illegal-step flag
//   locked      high while tracking (FSM in TRACK)
module count_monitor #(
    parameter int WIDTH  = 4,
    parameter int WRAP_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic [WIDTH-1:0]  count_in,
    input  logic              match_load,
    input  logic [WIDTH-1:0]  match_val,
    input  logic              clr_err,
    output logic              match,
    output logic              wrap,
    output logic [WRAP_W-1:0] wraps,
    output logic              step_err,
    output logic              locked
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        TRACK = 1'b1
    } state_t;

    localparam logic [WIDTH-1:0] MAX_COUNT  = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ZERO_COUNT = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE_COUNT  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WRAP_W-1:0] WRAPS_MAX = {WRAP_W{1'b1}};
    localparam logic [WRAP_W-1:0] WRAPS_ONE = {{(WRAP_W-1){1'b0}}, 1'b1};

    state_t            state_r;
    state_t            state_nxt_s;
    logic [WIDTH-1:0]  prev_r;
    logic [WIDTH-1:0]  prev_nxt_s;
    logic [WIDTH-1:0]  match_reg_r;
    logic              match_s;
    logic              wrap_s;
    logic              err_s;
    logic              match_r;
    logic              wrap_r;
    logic [WRAP_W-1:0] wraps_r;
    logic              step_err_r;
    logic              locked_r;

    // Next-state decode and step classification.
    // The first sample after IDLE only resynchronises prev and never produces events.
    // Wrap is tested before +1, because prev+1 overflows to 0 when prev is max.
    always_comb begin
        state_nxt_s = state_r;
        prev_nxt_s  = prev_r;
        match_s     = 1'b0;
        wrap_s      = 1'b0;
        err_s       = 1'b0;
        case (state_r)
            IDLE: begin
                if (en) begin
                    state_nxt_s = TRACK;
                    prev_nxt_s  = count_in;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            TRACK: begin
                if (en) begin
                    prev_nxt_s = count_in;
                    match_s    = (count_in != prev_r) && (count_in == match_reg_r);
                    if (count_in == prev_r) begin
                        wrap_s = 1'b0;
                    end else if ((prev_r == MAX_COUNT) && (count_in == ZERO_COUNT)) begin
                        wrap_s = 1'b1;
                    end else if (count_in == (prev_r + ONE_COUNT)) begin
                        wrap_s = 1'b0;
                    end else if (count_in == ZERO_COUNT) begin
                        wrap_s = 1'b0;
                    end else begin
                        err_s = 1'b1;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State, last sample and match register.
    // A match load takes effect for comparisons from the next edge onward.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            prev_r      <= ZERO_COUNT;
            match_reg_r <= ZERO_COUNT;
        end else begin
            state_r <= state_nxt_s;
            prev_r  <= prev_nxt_s;
            if (match_load) begin
                match_reg_r <= match_val;
            end else begin
                match_reg_r <= match_reg_r;
            end
        end
    end

    // Registered outputs.
    // The wrap tally saturates at its maximum value.
    // A new illegal step takes priority over clr_err.
    always_ff @(posedge clk) begin
        if (reset) begin
            match_r    <= 1'b0;
            wrap_r     <= 1'b0;
            wraps_r    <= {WRAP_W{1'b0}};
            step_err_r <= 1'b0;
            locked_r   <= 1'b0;
        end else begin
            match_r  <= match_s;
            wrap_r   <= wrap_s;
            locked_r <= (state_nxt_s == TRACK);
            if (wrap_s && (wraps_r != WRAPS_MAX)) begin
                wraps_r <= wraps_r + WRAPS_ONE;
            end else begin
                wraps_r <= wraps_r;
            end
            if (err_s) begin
                step_err_r <= 1'b1;
            end else if (clr_err) begin
                step_err_r <= 1'b0;
            end else begin
                step_err_r <= step_err_r;
            end
        end
    end

    assign match    = match_r;
    assign wrap     = wrap_r;
    assign wraps    = wraps_r;
    assign step_err = step_err_r;
    assign locked   = locked_r;

endmodule

// File: tb/tb_count_monitor.sv
module tb_count_monitor;

    logic       clk = 1'b0;
    logic       reset, en, match_load, clr_err;
    logic [3:0] count_in, match_val;
    logic       match, wrap, step_err, locked;
    logic [7:0] wraps;

    int errors = 0;
    int checks = 0;

    count_monitor #(.WIDTH(4), .WRAP_W(8)) dut (
        .clk(clk), .reset(reset), .en(en), .count_in(count_in),
        .match_load(match_load), .match_val(match_val), .clr_err(clr_err),
        .match(match), .wrap(wrap), .wraps(wraps), .step_err(step_err),
        .locked(locked)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       e;
        logic [3:0] cin;
        logic       ml;
        logic [3:0] mv;
        logic       ce;
        logic       x_match;
        logic       x_wrap;
        logic [7:0] x_wraps;
        logic       x_err;
        logic       x_locked;
    } vec_t;

    vec_t tbl[16];

    function automatic vec_t mk(input logic rst, input logic e, input logic [3:0] cin,
                                input logic ml, input logic [3:0] mv, input logic ce,
                                input logic xm, input logic xw, input logic [7:0] xws,
                                input logic xe, input logic xl);
        vec_t v;
        v.rst = rst; v.e = e; v.cin = cin; v.ml = ml; v.mv = mv; v.ce = ce;
        v.x_match = xm; v.x_wrap = xw; v.x_wraps = xws; v.x_err = xe; v.x_locked = xl;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, clock it, then settle past the edge
    task automatic apply(input logic rst, input logic e, input logic [3:0] cin,
                         input logic ml, input logic [3:0] mv, input logic ce);
        reset = rst; en = e; count_in = cin; match_load = ml; match_val = mv; clr_err = ce;
        @(posedge clk);
        #1;
    endtask

    // Reference model state
    bit m_locked;
    int m_prev, m_mreg, m_wraps;
    bit m_err, m_match, m_wrap;

    task automatic model(input bit rst, input bit e, input int cin, input bit ml,
                         input int mv, input bit ce);
        bit legal;
        m_match = 1'b0;
        m_wrap  = 1'b0;
        if (rst) begin
            m_locked = 1'b0; m_prev = 0; m_mreg = 0; m_wraps = 0; m_err = 1'b0;
        end else begin
            legal = 1'b1;
            if (e && m_locked) begin
                m_wrap  = (m_prev == 15) && (cin == 0);
                legal   = (cin == m_prev) || (cin == (m_prev + 1) % 16) || (cin == 0);
                m_match = (cin != m_prev) && (cin == m_mreg);
                if (m_wrap && m_wraps < 255) m_wraps = m_wraps + 1;
            end
            if (e) m_prev = cin;
            m_locked = e;
            if (!legal) m_err = 1'b1;
            else if (ce) m_err = 1'b0;
            if (ml) m_mreg = mv;
        end
    endtask

    initial begin
        int wrap_cnt;
        logic [3:0] cin;
        reset = 1'b1; en = 1'b0; count_in = 4'd0; match_load = 1'b0;
        match_val = 4'd0; clr_err = 1'b0;

        //             rst   en    cin    ml    mv     ce    match wrap  wraps  err   locked
        tbl[0]  = mk(1'b1, 1'b0, 4'd0,  1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
        tbl[1]  = mk(1'b0, 1'b1, 4'd0,  1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b1);
        tbl[2]  = mk(1'b0, 1'b1, 4'd1,  1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b1);
        tbl[3]  = mk(1'b0, 1'b1, 4'd3,  1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b1);
        tbl[4]  = mk(1'b0, 1'b1, 4'd4,  1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b1);
        tbl[5]  = mk(1'b0, 1'b1, 4'd4,  1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b1);
        tbl[6]  = mk(1'b0, 1'b1, 4'd0,  1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b1);
        tbl[7]  = mk(1'b0, 1'b1, 4'd0,  1'b1, 4'd2, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b1);
        tbl[8]  = mk(1'b0, 1'b1, 4'd1,  1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b1);
        tbl[9]  = mk(1'b0, 1'b1, 4'd2,  1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b1);
        tbl[10] = mk(1'b0, 1'b1, 4'd9,  1'b1, 4'd9, 1'b1, 1'b0, 1'b0, 8'd0, 1'b1, 1'b1);
        tbl[11] = mk(1'b0, 1'b0, 4'd10, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0);
        tbl[12] = mk(1'b0, 1'b1, 4'd15, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b1);
        tbl[13] = mk(1'b0, 1'b1, 4'd0,  1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 8'd1, 1'b1, 1'b1);
        tbl[14] = mk(1'b0, 1'b1, 4'd9,  1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 8'd1, 1'b1, 1'b1);
        tbl[15] = mk(1'b1, 1'b1, 4'd3,  1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0);

        for (int i = 0; i < 16; i++) begin
            apply(tbl[i].rst, tbl[i].e, tbl[i].cin, tbl[i].ml, tbl[i].mv, tbl[i].ce);
            check($sformatf("vec%0d {match,wrap,wraps,err,locked}", i),
                  {20'd0, match, wrap, wraps, step_err, locked},
                  {20'd0, tbl[i].x_match, tbl[i].x_wrap, tbl[i].x_wraps,
                   tbl[i].x_err, tbl[i].x_locked});
        end

        // Random stimulus against the model; the DUT is in reset state here
        model(1'b1, 1'b0, 0, 1'b0, 0, 1'b0);
        for (int c = 0; c < 3000; c++) begin
            int r;
            bit rst, e, ml, ce;
            int mv;
            r = $urandom_range(0, 99);
            if (r < 70)      cin = 4'((m_prev + 1) % 16);
            else if (r < 80) cin = 4'(m_prev);
            else if (r < 88) cin = 4'd0;
            else             cin = 4'($urandom_range(0, 15));
            rst = ($urandom_range(0, 199) == 0);
            e   = ($urandom_range(0, 19) != 0);
            ml  = ($urandom_range(0, 9) == 0);
            mv  = $urandom_range(0, 15);
            ce  = ($urandom_range(0, 14) == 0);
            apply(rst, e, cin, ml, 4'(mv), ce);
            model(rst, e, int'(cin), ml, mv, ce);
            check($sformatf("rand%0d {match,wrap,wraps,err,locked}", c),
                  {20'd0, match, wrap, wraps, step_err, locked},
                  {20'd0, m_match, m_wrap, 8'(m_wraps), m_err, m_locked});
        end

        // Wrap saturation: 300 full wraps from reset
        apply(1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
        apply(1'b0, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0);
        wrap_cnt = 0;
        for (int w = 0; w < 300; w++) begin
            for (int v = 1; v < 16; v++) begin
                apply(1'b0, 1'b1, 4'(v), 1'b0, 4'd0, 1'b0);
                if (wrap) wrap_cnt++;
            end
            apply(1'b0, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0);
            if (wrap) wrap_cnt++;
        end
        check("sat last wrap pulse", {31'd0, wrap}, 32'd1);
        check("sat wraps", {24'd0, wraps}, 32'd255);
        check("sat wrap pulse count", wrap_cnt, 32'd300);
        check("sat step_err", {31'd0, step_err}, 32'd0);

        // Enable drop: 4 -> (en low, 11) -> 11 re-sampled, no error or events
        apply(1'b0, 1'b1, 4'd1, 1'b0, 4'd0, 1'b0);
        apply(1'b0, 1'b1, 4'd2, 1'b0, 4'd0, 1'b0);
        apply(1'b0, 1'b1, 4'd3, 1'b0, 4'd0, 1'b0);
        apply(1'b0, 1'b1, 4'd4, 1'b0, 4'd0, 1'b0);
        apply(1'b0, 1'b0, 4'd11, 1'b0, 4'd0, 1'b0);
        check("drop locked low", {31'd0, locked}, 32'd0);
        apply(1'b0, 1'b1, 4'd11, 1'b0, 4'd0, 1'b0);
        check("drop relock {match,wrap,err,locked}",
              {28'd0, match, wrap, step_err, locked}, 32'h1);
        apply(1'b0, 1'b1, 4'd12, 1'b0, 4'd0, 1'b0);
        check("drop next step err", {31'd0, step_err}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
